// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths and the read-side drain state encoding.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order {data,last} buffer; entry 0 is the head and drives the output.
module fifo_skid_buf #(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data0_q;
  assign out_last  = last0_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    data0_d = data0_q;
    last0_d = last0_q;
    data1_d = data1_q;
    last1_d = last1_q;
    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    // A push lands in the first slot that is free after this cycle's pop.
    if (push) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        data0_d = in_data;
        last0_d = in_last;
      end else begin
        data1_d = in_data;
        last1_d = in_last;
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_q <= '0;
      last0_q <= 1'b0;
      data1_q <= '0;
      last1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      data0_q <= data0_d;
      last0_q <= last0_d;
      data1_q <= data1_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side consumer: pops words into a skid buffer and streams them out with
// burst framing; dropping enable mid-burst drains to the burst boundary before idling.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int BP_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BP_W-1:0] BP_LAST = BP_W'(BURST_LEN - 1);

  rd_state_e            state_q, state_d;
  logic [BP_W-1:0]      burst_pos_q, burst_pos_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                 pop_last;
  logic                 buf_in_ready;
  logic [1:0]           buf_count;

  assign pop_last = (burst_pos_q == BP_LAST);
  assign rd_count = rd_count_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= IDLE;
      burst_pos_q <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_pos_q <= burst_pos_d;
      rd_count_q  <= rd_count_d;
    end
  end

  always_comb begin
    burst_pos_d = burst_pos_q;
    rd_count_d  = rd_count_q;
    if (rinc) begin
      burst_pos_d = pop_last ? '0 : burst_pos_q + 1'b1;
      rd_count_d  = rd_count_q + 1'b1;
    end
  end

  // Leaving RUN looks at the post-pop position, so IDLE is only ever entered at a boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = (burst_pos_d != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable)                state_d = RUN;
        else if (rinc && pop_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rinc = (state_q == RUN || state_q == DRAIN) && !rempty && buf_in_ready;
    busy = (state_q != IDLE) || (buf_count != 2'd0);
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (rclk),
    .rst      (rrst),
    .in_valid (rinc),
    .in_ready (buf_in_ready),
    .in_data  (rdata),
    .in_last  (pop_last),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .out_last (m_last),
    .count    (buf_count)
  );

  a_rinc_not_empty: assert property (@(posedge rclk) disable iff (rrst)
    rinc |-> !rempty);

  a_stream_hold: assert property (@(posedge rclk) disable iff (rrst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule
